// File: rtl/seg7_scan_capture.sv
// seg7_scan_capture
//   Reads back a multiplexed seven-segment display bus. Each clock the
//   bus {num_csn, num_a_g} is sampled. When STABLE_CYCLES identical samples
//   have been seen, the settled value is classified once: it is a blank, a
//   select error, a legal hex glyph for one digit, or a bad segment pattern.
//   An 8-digit hex image of the display is kept.
//
//   Parameter
//     STABLE_CYCLES : identical consecutive samples needed before a capture
//                     (legal range 1..255)
//
//   Ports
//     clk        system clock
//     resetn     asynchronous active-low reset
//     num_csn    [7:0] digit selects, active low (bit i low = digit i)
//     num_a_g    [6:0] segments, active high, {a,b,c,d,e,f,g}, a = bit 6
//     digits     [31:0] captured image, digit i at [4i+3:4i]
//     dig_valid  [7:0] bit i set once digit i has had a legal capture
//     update     one-cycle pulse, a digit was written
//     upd_idx    [2:0] index of the last digit written or flagged
//     seg_err    one-cycle pulse, settled segments are not a hex glyph
//     sel_err    one-cycle pulse, settled selects have more than one bit low
//
//   Optional build macro SEG7_CAP_RAW_EN
//     Adds raw_seg[55:0]; slot i at [7i+6:7i] holds the last settled
//     num_a_g seen for digit i (written on update and seg_err events).

module seg7_scan_capture #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [7:0]  num_csn,
  input  logic [6:0]  num_a_g,
  output logic [31:0] digits,
  output logic [7:0]  dig_valid,
  output logic        update,
  output logic [2:0]  upd_idx,
  output logic        seg_err,
`ifdef SEG7_CAP_RAW_EN
  output logic        sel_err,
  output logic [55:0] raw_seg
`else
  output logic        sel_err
`endif
);

  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);

  logic [14:0] sample;
  logic [14:0] s_cur;
  logic [7:0]  cnt;
  logic        armed;
  logic        changed;
  logic        settle;

  logic [7:0]  cur_csn;
  logic [6:0]  cur_seg;
  logic [3:0]  low_count;
  logic [2:0]  sel_idx;
  logic        glyph_hit;
  logic [3:0]  glyph_val;

  // Number of active (low) select lines.
  function automatic logic [3:0] count_low(input logic [7:0] v);
    logic [3:0] c;
    c = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      c = c + 4'(~v[i]);
    end
    return c;
  endfunction

  // Index of the lowest active select line.
  function automatic logic [2:0] low_index(input logic [7:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int i = 7; i >= 0; i--) begin
      if (!v[i]) begin
        idx = 3'(i);
      end
    end
    return idx;
  endfunction

  // Segment pattern -> {hit, hex value}.
  function automatic logic [4:0] decode_glyph(input logic [6:0] seg);
    logic [4:0] r;
    case (seg)
      7'h7E:   r = {1'b1, 4'h0};
      7'h30:   r = {1'b1, 4'h1};
      7'h6D:   r = {1'b1, 4'h2};
      7'h79:   r = {1'b1, 4'h3};
      7'h33:   r = {1'b1, 4'h4};
      7'h5B:   r = {1'b1, 4'h5};
      7'h5F:   r = {1'b1, 4'h6};
      7'h70:   r = {1'b1, 4'h7};
      7'h7F:   r = {1'b1, 4'h8};
      7'h7B:   r = {1'b1, 4'h9};
      7'h77:   r = {1'b1, 4'hA};
      7'h1F:   r = {1'b1, 4'hB};
      7'h4E:   r = {1'b1, 4'hC};
      7'h3D:   r = {1'b1, 4'hD};
      7'h4F:   r = {1'b1, 4'hE};
      7'h47:   r = {1'b1, 4'hF};
      default: r = {1'b0, 4'h0};
    endcase
    return r;
  endfunction

  // The incoming sample is compared with the held one, which is the same
  // test as comparing the two held samples one edge later; this lets the
  // result registers fire on edge E0+STABLE_CYCLES without a third stage.
  assign sample  = {num_csn, num_a_g};
  assign changed = (sample != s_cur);
  assign settle  = armed && (cnt == CNT_MAX);

  assign cur_csn = s_cur[14:7];
  assign cur_seg = s_cur[6:0];

  always_comb begin
    low_count             = count_low(cur_csn);
    sel_idx               = low_index(cur_csn);
    {glyph_hit, glyph_val} = decode_glyph(cur_seg);
  end

  // Sampling and settle detection.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s_cur <= '1;
      cnt   <= '0;
      armed <= 1'b1;
    end else begin
      s_cur <= sample;
      if (changed) begin
        cnt   <= '0;
        armed <= 1'b1;
      end else begin
        if (cnt != CNT_MAX) begin
          cnt <= cnt + 8'd1;
        end
        if (settle) begin
          armed <= 1'b0;
        end
      end
    end
  end

  // Event classification and display image.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      digits    <= '0;
      dig_valid <= '0;
      update    <= 1'b0;
      upd_idx   <= '0;
      seg_err   <= 1'b0;
      sel_err   <= 1'b0;
`ifdef SEG7_CAP_RAW_EN
      raw_seg   <= '0;
`endif
    end else begin
      update  <= 1'b0;
      seg_err <= 1'b0;
      sel_err <= 1'b0;
      if (settle && (cur_csn != 8'hFF)) begin
        if (low_count > 4'd1) begin
          sel_err <= 1'b1;
        end else begin
          upd_idx <= sel_idx;
`ifdef SEG7_CAP_RAW_EN
          raw_seg[7*sel_idx +: 7] <= cur_seg;
`endif
          if (glyph_hit) begin
            digits[{sel_idx, 2'b00} +: 4] <= glyph_val;
            dig_valid[sel_idx]            <= 1'b1;
            update                        <= 1'b1;
          end else begin
            seg_err <= 1'b1;
          end
        end
      end
    end
  end

endmodule
